axi_lite_slave_mem: RTL

//  AXI4-Lite slave endpoint: word-organised register memory that consumes the slave side of
//  axi_lite_if. Sits directly downstream of the AXI4-Lite master; services one outstanding

---
 rtl/axi_lite_slave_mem.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a small word-organised register memory with byte strobes.
// Optional macro AXIL_SLV_ERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * STRB_W);
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state_reg, w_state_next;
    r_state_t r_state_reg, r_state_next;

    logic                  init_reg;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]     wstrb_reg;
    logic [1:0]            bresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] commit_addr, wr_off, rd_off;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb, lane_we;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_in, rd_in;
    logic [1:0]            wr_resp, rd_resp;

    // Readies depend only on state and the init flag, never on the matching valid.
    assign awready = init_reg && (w_state_reg == W_IDLE || w_state_reg == W_DATA);
    assign wready  = init_reg && (w_state_reg == W_IDLE || w_state_reg == W_ADDR);
    assign arready = init_reg && (r_state_reg == R_IDLE);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    assign bvalid  = (w_state_reg == W_RESP);
    assign bresp   = bresp_reg;
    assign rvalid  = (r_state_reg == R_DATA);
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

    // Whichever half arrived first was parked in a register; the other comes from the bus.
    assign commit_addr = (w_state_reg == W_ADDR) ? aw_addr_reg : awaddr;
    assign commit_data = (w_state_reg == W_DATA) ? wdata_reg : wdata;
    assign commit_strb = (w_state_reg == W_DATA) ? wstrb_reg : wstrb;

    // Unsigned offset wraps for addresses below the base, so one compare covers both bounds.
    assign wr_off = commit_addr - BASE_ADDR;
    assign rd_off = araddr - BASE_ADDR;
    assign wr_in  = (wr_off < SPAN);
    assign rd_in  = (rd_off < SPAN);
    assign wr_idx = wr_off[LSB +: IDX_W];
    assign rd_idx = rd_off[LSB +: IDX_W];

`ifdef AXIL_SLV_ERR_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    assign wr_resp = wr_in ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = rd_in ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane_we
            assign lane_we[gi] = commit && wr_in && commit_strb[gi];
        end
    endgenerate

    always_comb begin
        w_state_next = w_state_reg;
        commit       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end else if (aw_hs) begin
                    w_state_next = W_ADDR;
                end else if (w_hs) begin
                    w_state_next = W_DATA;
                end
            end
            W_ADDR: begin
                if (w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_DATA: begin
                if (aw_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // A read sampled on the commit edge sees the pre-write word (no bypass).
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            init_reg    <= 1'b0;
            w_state_reg <= W_IDLE;
            r_state_reg <= R_IDLE;
            aw_addr_reg <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            init_reg    <= 1'b1;
            w_state_reg <= w_state_next;
            r_state_reg <= r_state_next;
            if (aw_hs) aw_addr_reg <= awaddr;
            if (w_hs) begin
                wdata_reg <= wdata;
                wstrb_reg <= wstrb;
            end
            if (commit) bresp_reg <= wr_resp;
            for (int i = 0; i < STRB_W; i++) begin
                if (lane_we[i]) mem[wr_idx][i*8 +: 8] <= commit_data[i*8 +: 8];
            end
            if (ar_hs) begin
                rdata_reg <= rd_in ? mem[rd_idx] : '0;
                rresp_reg <= rd_resp;
            end
        end
    end
endmodule
